// File: rtl/npu_pkg.sv
// Shared types and constants for the convolution back-end pooling stage.
package npu_pkg;

   localparam int CONV_IN_W = 16;  // element width produced by the tile engine
   localparam int POOL_WIN  = 2;   // pooling window edge (2x2, stride 2)
   localparam int TILE_OUT  = 4;   // bytes emitted per 4x4 tile

   // One 4x4 tile of convolution results, row-major [row][col].
   typedef logic [0:3][0:3][CONV_IN_W-1:0] conv_tile_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POOL = 2'd1,
      EMIT = 2'd2
   } pool_state_e;

endpackage

// File: rtl/pool_quant_unit.sv
// Combinational max-of-4, right shift and unsigned saturation to OUT_W bits.
module pool_quant_unit #(
   parameter int SHIFT = 4,
   parameter int IN_W  = 16,
   parameter int OUT_W = 8
) (
   input  logic [IN_W-1:0]  a_i,
   input  logic [IN_W-1:0]  b_i,
   input  logic [IN_W-1:0]  c_i,
   input  logic [IN_W-1:0]  d_i,
   output logic [OUT_W-1:0] q_o
);

   // Largest value representable in the output byte.
   localparam logic [IN_W-1:0] SAT_MAX = IN_W'((1 << OUT_W) - 1);

   logic [IN_W-1:0] max_ab;
   logic [IN_W-1:0] max_cd;
   logic [IN_W-1:0] mx;
   logic [IN_W-1:0] shifted;

   // Reduce the window to its maximum, then requantise with saturation.
   always_comb begin
      max_ab  = (a_i > b_i) ? a_i : b_i;
      max_cd  = (c_i > d_i) ? c_i : d_i;
      mx      = (max_ab > max_cd) ? max_ab : max_cd;
      shifted = mx >> SHIFT;
      q_o     = (shifted > SAT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
   end

endmodule

// File: rtl/conv_pool_quant.sv
// Captures a 4x4 conv tile on conv_done rising edge, 2x2 max-pools and
// requantises it over four cycles, then streams four bytes valid/ready.
module conv_pool_quant
   import npu_pkg::*;
#(
   parameter int SHIFT = 4,
   parameter int IN_W  = 16,
   parameter int OUT_W = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        conv_done,
   input  logic [0:3][0:3][IN_W-1:0]   conv_c,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [OUT_W-1:0]            m_data,
   output logic                        m_last,
   output logic                        busy,
   output logic                        overrun
);

   pool_state_e state_q, state_d;
   logic [1:0]  k_q, k_d;
   logic [1:0]  e_q, e_d;
   logic        done_q;
   logic        armed_q;
   logic        overrun_q;
   logic        cap_en;
   logic        pool_en;
   logic        tile_evt;

   logic [0:3][0:3][IN_W-1:0]  cap_q;
   logic [0:3][OUT_W-1:0]      pooled_q;

   logic [1:0]       r0, r1, c0, c1;
   logic [IN_W-1:0]  win_a, win_b, win_c, win_d;
   logic [OUT_W-1:0] pool_byte;

   // armed_q suppresses an event on the first edge after reset so that a
   // conv_done still high from before reset is not mistaken for a new tile.
   assign tile_evt = conv_done & ~done_q & armed_q;

   // Select the 2x2 window addressed by k: k[1] picks the row pair, k[0] the column pair.
   always_comb begin
      r0    = {k_q[1], 1'b0};
      r1    = {k_q[1], 1'b1};
      c0    = {k_q[0], 1'b0};
      c1    = {k_q[0], 1'b1};
      win_a = cap_q[r0][c0];
      win_b = cap_q[r0][c1];
      win_c = cap_q[r1][c0];
      win_d = cap_q[r1][c1];
   end

   pool_quant_unit #(
      .SHIFT (SHIFT),
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_pq (
      .a_i (win_a),
      .b_i (win_b),
      .c_i (win_c),
      .d_i (win_d),
      .q_o (pool_byte)
   );

   // Next-state logic: capture, four pooling cycles, then four handshaked beats.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      e_d     = e_q;
      cap_en  = 1'b0;
      pool_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tile_evt) begin
               cap_en  = 1'b1;
               k_d     = 2'd0;
               state_d = POOL;
            end
         end
         POOL: begin
            pool_en = 1'b1;
            k_d     = k_q + 2'd1;
            if (k_q == 2'd3) begin
               e_d     = 2'd0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (m_ready) begin
               e_d = e_q + 2'd1;
               if (e_q == 2'd3) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, indices, edge detector and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= 2'd0;
         e_q       <= 2'd0;
         done_q    <= 1'b0;
         armed_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         e_q       <= e_d;
         done_q    <= conv_done;
         armed_q   <= 1'b1;
         if (tile_evt && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   // Tile capture and per-window pooled results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_q    <= '0;
         pooled_q <= '0;
      end else begin
         if (cap_en) begin
            cap_q <= conv_c;
         end
         if (pool_en) begin
            pooled_q[k_q] <= pool_byte;
         end
      end
   end

   // Stream outputs decode straight from registers; m_ready never reaches m_valid.
   assign m_valid = (state_q == EMIT);
   assign m_data  = pooled_q[e_q];
   assign m_last  = (state_q == EMIT) && (e_q == 2'd3);
   assign busy    = (state_q != IDLE);
   assign overrun = overrun_q;

endmodule
